// File: rtl/prog_loader.sv
// Boot loader: streams instruction words then data words into the two BRAM write ports,
// then releases the core. Optional build macro: PROG_LOADER_CHECKSUM_EN (trailing checksum beat).
module prog_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  i_count,
    input  logic [CNT_W-1:0]  d_count,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] i_w_addr,
    output logic [DATA_W-1:0] i_w_dat,
    output logic              i_w_enb,
    output logic [3:0]        i_w_byte_enb,
    output logic [ADDR_W-1:0] d_w_addr,
    output logic [DATA_W-1:0] d_w_dat,
    output logic              d_w_enb,
    output logic [3:0]        d_w_byte_enb,
    output logic              d_bram_init_done,
    output logic              cpu_rst,
    output logic              pc_stall,
    output logic              i_r_enb,
    output logic              rd_enbl,
    output logic              busy,
    output logic              error,
    output logic [2:0]        state_dbg
);

    // Stream handshake: a word transfers on a rising edge where s_valid && s_ready;
    // s_ready depends only on state, and s_data must be stable while s_valid is high.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_I    = 3'd1,
        LOAD_D    = 3'd2,
        LOAD_CSUM = 3'd3,
        RELEASE   = 3'd4,
        RUN       = 3'd5,
        ERROR     = 3'd6
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t LOAD_END = LOAD_CSUM;
`else
    localparam state_t LOAD_END = RELEASE;
`endif

    localparam int               MAX_WORDS_INT = 1 << (ADDR_W - 2);
    localparam logic [CNT_W-1:0] MAX_WORDS     = CNT_W'(MAX_WORDS_INT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] i_cnt, d_cnt, idx;
    logic             accept, last_i, last_d, go_load, load_beat;

    assign accept    = s_valid & s_ready;
    assign last_i    = (idx == i_cnt - CNT_W'(1));
    assign last_d    = (idx == d_cnt - CNT_W'(1));
    assign go_load   = (state == IDLE) && start;
    assign load_beat = accept && ((state == LOAD_I) || (state == LOAD_D));
    assign state_dbg = state;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    logic              csum_ok;
    assign csum_ok = (s_data == csum);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        s_ready          = 1'b0;
        busy             = 1'b0;
        cpu_rst          = 1'b1;
        pc_stall         = 1'b1;
        i_r_enb          = 1'b0;
        rd_enbl          = 1'b0;
        d_bram_init_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (i_count != '0)      state_nxt = LOAD_I;
                    else if (d_count != '0) state_nxt = LOAD_D;
                    else                    state_nxt = RELEASE;
                end
            end
            LOAD_I: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (accept && last_i) state_nxt = (d_cnt != '0) ? LOAD_D : LOAD_END;
            end
            LOAD_D: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (accept && last_d) state_nxt = LOAD_END;
            end
            LOAD_CSUM: begin
                s_ready = 1'b1;
                busy    = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                if (accept) state_nxt = csum_ok ? RELEASE : ERROR;
`else
                state_nxt = IDLE;
`endif
            end
            RELEASE: begin
                busy      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                cpu_rst          = 1'b0;
                pc_stall         = 1'b0;
                i_r_enb          = 1'b1;
                rd_enbl          = 1'b1;
                d_bram_init_done = 1'b1;
                if (start) state_nxt = IDLE;
            end
            ERROR: begin
                if (start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write ports are registered: each accepted beat becomes a one-cycle write on the next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_cnt        <= '0;
            d_cnt        <= '0;
            idx          <= '0;
            error        <= 1'b0;
            i_w_addr     <= '0;
            i_w_dat      <= '0;
            i_w_enb      <= 1'b0;
            i_w_byte_enb <= 4'b0000;
            d_w_addr     <= '0;
            d_w_dat      <= '0;
            d_w_enb      <= 1'b0;
            d_w_byte_enb <= 4'b0000;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            i_w_enb      <= 1'b0;
            i_w_byte_enb <= 4'b0000;
            d_w_enb      <= 1'b0;
            d_w_byte_enb <= 4'b0000;
            if (go_load) begin
                // Counts beyond one BRAM's worth would wrap the address; clamp and flag.
                i_cnt <= (i_count > MAX_WORDS) ? MAX_WORDS : i_count;
                d_cnt <= (d_count > MAX_WORDS) ? MAX_WORDS : d_count;
                error <= (i_count > MAX_WORDS) || (d_count > MAX_WORDS);
                idx   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum  <= '0;
`endif
            end
            if (load_beat) begin
                if (state == LOAD_I) begin
                    i_w_enb      <= 1'b1;
                    i_w_byte_enb <= 4'b1111;
                    i_w_dat      <= s_data;
                    i_w_addr     <= ADDR_W'({idx, 2'b00});
                    idx          <= last_i ? '0 : idx + CNT_W'(1);
                end else begin
                    d_w_enb      <= 1'b1;
                    d_w_byte_enb <= 4'b1111;
                    d_w_dat      <= s_data;
                    d_w_addr     <= ADDR_W'({idx, 2'b00});
                    idx          <= last_d ? '0 : idx + CNT_W'(1);
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                csum <= csum + s_data;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if (accept && (state == LOAD_CSUM) && !csum_ok) error <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a word-list model predicts every BRAM write and the
// control outputs around each load, reload, mid-load reset and count clamp.
module tb_prog_loader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 11;
    localparam int MAXW   = 1024;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  i_count, d_count;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [ADDR_W-1:0] i_w_addr, d_w_addr;
    logic [DATA_W-1:0] i_w_dat, d_w_dat;
    logic              i_w_enb, d_w_enb;
    logic [3:0]        i_w_byte_enb, d_w_byte_enb;
    logic              d_bram_init_done, cpu_rst, pc_stall, i_r_enb, rd_enbl, busy, error;
    logic [2:0]        state_dbg;

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .i_count(i_count), .d_count(d_count),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb), .i_w_byte_enb(i_w_byte_enb),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb), .d_w_byte_enb(d_w_byte_enb),
        .d_bram_init_done(d_bram_init_done), .cpu_rst(cpu_rst), .pc_stall(pc_stall),
        .i_r_enb(i_r_enb), .rd_enbl(rd_enbl), .busy(busy), .error(error), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W+DATA_W-1:0] exp_i_q[$];
    logic [ADDR_W+DATA_W-1:0] exp_d_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_i_w_addr"}, 32'(i_w_addr), 0);
        check({pfx, "_i_w_dat"}, i_w_dat, 0);
        check({pfx, "_i_w_enb"}, 32'(i_w_enb), 0);
        check({pfx, "_i_w_be"}, 32'(i_w_byte_enb), 0);
        check({pfx, "_d_w_addr"}, 32'(d_w_addr), 0);
        check({pfx, "_d_w_dat"}, d_w_dat, 0);
        check({pfx, "_d_w_enb"}, 32'(d_w_enb), 0);
        check({pfx, "_d_w_be"}, 32'(d_w_byte_enb), 0);
        check({pfx, "_s_ready"}, 32'(s_ready), 0);
        check({pfx, "_init_done"}, 32'(d_bram_init_done), 0);
        check({pfx, "_cpu_rst"}, 32'(cpu_rst), 1);
        check({pfx, "_pc_stall"}, 32'(pc_stall), 1);
        check({pfx, "_i_r_enb"}, 32'(i_r_enb), 0);
        check({pfx, "_rd_enbl"}, 32'(rd_enbl), 0);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_error"}, 32'(error), 0);
    endtask

    // vmode: 0 continuous valid, 1 toggling 1-0-1-0, 2 random. poke: pulse start mid-load.
    task automatic do_load(input int ni_req, input int nd_req, input int vmode, input bit poke);
        int ni, nd, total, k, pend, cyc;
        bit exp_err, v;
        logic [31:0] w[$];
        logic [31:0] sum, word;
        logic [ADDR_W+DATA_W-1:0] e;
        ni = (ni_req > MAXW) ? MAXW : ni_req;
        nd = (nd_req > MAXW) ? MAXW : nd_req;
        exp_err = (ni_req > MAXW) || (nd_req > MAXW);
        exp_i_q.delete();
        exp_d_q.delete();
        sum = 0;
        for (int j = 0; j < ni + nd; j++) begin
            word = $urandom;
            w.push_back(word);
            sum += word;
            if (j < ni) exp_i_q.push_back({ADDR_W'(4 * j), word});
            else        exp_d_q.push_back({ADDR_W'(4 * (j - ni)), word});
        end
        if (CS == 1) w.push_back(sum);
        total = ni + nd + CS;

        start = 1'b1;
        i_count = CNT_W'(ni_req);
        d_count = CNT_W'(nd_req);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("error_latch", 32'(error), 32'(exp_err));

        k = 0; pend = 0; cyc = 0;
        while (1) begin
            check("i_w_enb", 32'(i_w_enb), 32'(pend == 1));
            check("d_w_enb", 32'(d_w_enb), 32'(pend == 2));
            if (pend == 1) begin
                if (exp_i_q.size() == 0) check("i_write_extra", 1, 0);
                else begin
                    e = exp_i_q.pop_front();
                    check("i_w_addr", 32'(i_w_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                    check("i_w_dat", i_w_dat, e[DATA_W-1:0]);
                    check("i_w_be", 32'(i_w_byte_enb), 32'hf);
                end
            end else if (pend == 2) begin
                if (exp_d_q.size() == 0) check("d_write_extra", 1, 0);
                else begin
                    e = exp_d_q.pop_front();
                    check("d_w_addr", 32'(d_w_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                    check("d_w_dat", d_w_dat, e[DATA_W-1:0]);
                    check("d_w_be", 32'(d_w_byte_enb), 32'hf);
                end
            end else begin
                check("be_idle", 32'({i_w_byte_enb, d_w_byte_enb}), 0);
            end
            check("s_ready", 32'(s_ready), 32'(k < total));
            if (k == total) break;
            if (cyc > 5000) begin
                check("load_timeout", 1, 0);
                break;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid = v;
            s_data  = v ? w[k] : $urandom;
            if (poke && k == 2) begin
                start = 1'b1; i_count = 1; d_count = 1;
            end else start = 1'b0;
            pend = !v ? 0 : (k < ni) ? 1 : (k < ni + nd) ? 2 : 0;
            if (v) k++;
            cyc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        start = 1'b0;
        check("release_busy", 32'(busy), 1);
        check("release_cpu_rst", 32'(cpu_rst), 1);
        check("release_pc_stall", 32'(pc_stall), 1);
        check("release_init_done", 32'(d_bram_init_done), 0);
        check("i_writes_missing", exp_i_q.size(), 0);
        check("d_writes_missing", exp_d_q.size(), 0);
        @(negedge clk);
        check("run_cpu_rst", 32'(cpu_rst), 0);
        check("run_pc_stall", 32'(pc_stall), 0);
        check("run_init_done", 32'(d_bram_init_done), 1);
        check("run_busy", 32'(busy), 0);
        check("run_i_r_enb", 32'(i_r_enb), 1);
        check("run_rd_enbl", 32'(rd_enbl), 1);
        check("run_s_ready", 32'(s_ready), 0);
        check("run_no_write", 32'({i_w_enb, d_w_enb}), 0);
        check("run_error", 32'(error), 32'(exp_err));
    endtask

    task automatic reload_from_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("reload_pc_stall", 32'(pc_stall), 1);
        check("reload_cpu_rst", 32'(cpu_rst), 1);
        check("reload_init_done", 32'(d_bram_init_done), 0);
        check("reload_busy", 32'(busy), 0);
        check("reload_i_r_enb", 32'(i_r_enb), 0);
        check("reload_rd_enbl", 32'(rd_enbl), 0);
        check("reload_s_ready", 32'(s_ready), 0);
    endtask

    task automatic reset_mid_load();
        int writes, cyc;
        writes = 0;
        cyc = 0;
        start = 1'b1; i_count = 5; d_count = 4;
        @(negedge clk);
        start = 1'b0;
        s_valid = 1'b1;
        while (writes < 2 && cyc < 20) begin
            s_data = $urandom;
            @(negedge clk);
            if (i_w_enb) writes++;
            cyc++;
        end
        check("midrst_two_writes", writes, 2);
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (3) begin
            @(negedge clk);
            check("midrst_hold_no_write", 32'({i_w_enb, d_w_enb}), 0);
            check("midrst_hold_s_ready", 32'(s_ready), 0);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_write", 32'({i_w_enb, d_w_enb}), 0);
            check("post_rst_s_ready", 32'(s_ready), 0);
            check("post_rst_busy", 32'(busy), 0);
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; i_count = '0; d_count = '0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        do_load(5, 4, 0, 1'b0);
        reload_from_run();
        do_load(5, 4, 1, 1'b0);
        reload_from_run();
        do_load(3, 0, 2, 1'b1);
        reload_from_run();
        reset_mid_load();
        do_load(1100, 2, 0, 1'b0);
        reload_from_run();
        do_load(4, 3, 2, 1'b0);
        for (int r = 0; r < 4; r++) begin
            reload_from_run();
            do_load($urandom_range(1, 16), $urandom_range(0, 16), 2, r[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
